ibex_hpm_counter_bank: RTL



---
 rtl/ibex_hpm_counter_bank_pkg.sv | 28 ++
 rtl/ibex_hpm_counter.sv | 36 +++
 rtl/ibex_hpm_counter_bank.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ibex_hpm_counter_bank_pkg.sv
// Shared constants for the HPM counter bank: CSR address map and implemented-counter mask.
package ibex_hpm_counter_bank_pkg;

  localparam int unsigned HPM_MAX_COUNTERS     = 29;
  localparam logic [11:0] CSR_OFF_MHPMEVENT    = 12'h323;
  localparam logic [11:0] CSR_OFF_MCOUNTER     = 12'hB00;
  localparam logic [11:0] CSR_OFF_MCOUNTERH    = 12'hB80;
  localparam int unsigned CSR_MHPMEVENT_OF_BIT = 31;

  typedef enum logic [11:0] {
    CSR_MCOUNTINHIBIT = 12'h320,
    CSR_MCYCLE        = 12'hB00,
    CSR_MINSTRET      = 12'hB02,
    CSR_MCYCLEH       = 12'hB80,
    CSR_MINSTRETH     = 12'hB82
  } csr_num_e;

  // Bit N set when counter N exists: mcycle, minstret and mhpmcounter3..3+num_counters-1.
  function automatic logic [31:0] hpm_impl_mask(int unsigned num_counters);
    logic [31:0] mask;
    mask = 32'h0000_0005;
    for (int unsigned i = 0; i < HPM_MAX_COUNTERS; i++) begin
      if (i < num_counters) mask[5'(i + 3)] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/ibex_hpm_counter.sv
// One counter of configurable width presented as a 64-bit CSR pair.
// A write to either half overrides a same-cycle increment; the other half is preserved.
module ibex_hpm_counter #(
  parameter int unsigned Width = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o,
  output logic        wrap_c
);

  logic [Width-1:0] r_count;
  logic [63:0]      w_full;
  logic [63:0]      w_wr_val;

  assign w_full   = 64'(r_count);
  assign w_wr_val = we_lo_i ? {w_full[63:32], wdata_i} : {wdata_i, w_full[31:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (we_lo_i || we_hi_i) begin
      r_count <= Width'(w_wr_val);
    end else if (inc_i) begin
      r_count <= r_count + Width'(1);
    end
  end

  assign value_o = w_full;
  assign wrap_c  = inc_i && !we_lo_i && !we_hi_i && (&r_count);

endmodule

// File: rtl/ibex_hpm_counter_bank.sv
// Machine counter bank: mcycle, minstret, mhpmcounterN with mhpmevent masks and mcountinhibit.
// Per-counter overflow flags and ovf_irq_o are built only when IBEX_HPM_OVF_IRQ_EN is defined.
module ibex_hpm_counter_bank
  import ibex_hpm_counter_bank_pkg::*;
#(
  parameter int unsigned NumCounters  = 10,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [11:0]          csr_addr_i,
  input  logic                 csr_we_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_hit_o,
  input  logic                 instr_ret_i,
  input  logic [NumEvents-1:0] event_i,
  input  logic                 debug_stopcount_i,
  output logic                 ovf_irq_o
);

  localparam logic [31:0] ImplMask   = hpm_impl_mask(NumCounters);
  localparam logic [31:0] InhibitRst = ImplMask & 32'hFFFF_FFF8;

  logic [4:0]  w_idx;
  logic        w_sel_inh;
  logic        w_sel_evt;
  logic        w_sel_lo;
  logic        w_sel_hi;
  logic [31:0] r_inhibit;
  logic [63:0] w_val    [32];
  logic [31:0] w_evt_rd [32];
  logic [31:0] w_wrap;
  logic [31:0] w_of;
  logic        w_unused_wrap;

  // Address decode; the time CSRs (index 1) are deliberately not claimed.
  assign w_idx     = csr_addr_i[4:0];
  assign w_sel_inh = (csr_addr_i == CSR_MCOUNTINHIBIT);
  assign w_sel_evt = (csr_addr_i[11:5] == CSR_OFF_MHPMEVENT[11:5]) &&
                     (w_idx >= CSR_OFF_MHPMEVENT[4:0]);
  assign w_sel_lo  = (csr_addr_i[11:5] == CSR_OFF_MCOUNTER[11:5]) && (w_idx != 5'd1);
  assign w_sel_hi  = (csr_addr_i[11:5] == CSR_OFF_MCOUNTERH[11:5]) && (w_idx != 5'd1);
  assign csr_hit_o = w_sel_inh || w_sel_evt || w_sel_lo || w_sel_hi;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inhibit <= InhibitRst;
    end else if (csr_we_i && w_sel_inh) begin
      r_inhibit <= csr_wdata_i & ImplMask;
    end
  end

  for (genvar n = 0; n < 32; n++) begin : g_ctr
    if (n == 0 || n == 2 || (n >= 3 && n < 3 + NumCounters)) begin : g_impl
      localparam int unsigned W = (n < 3) ? 64 : CounterWidth;
      logic w_src;
      logic w_inc;
      logic w_we_lo;
      logic w_we_hi;

      if (n == 0) begin : g_src_cycle
        assign w_src       = 1'b1;
        assign w_evt_rd[n] = '0;
        assign w_of[n]     = 1'b0;
      end else if (n == 2) begin : g_src_instret
        assign w_src       = instr_ret_i;
        assign w_evt_rd[n] = '0;
        assign w_of[n]     = 1'b0;
      end else begin : g_hpm
        logic [NumEvents-1:0] r_mask;
        logic [31:0]          w_rd;
        logic                 w_we_evt;

        assign w_we_evt = csr_we_i && w_sel_evt && (w_idx == 5'(n));

        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            r_mask <= '0;
          end else if (w_we_evt) begin
            r_mask <= csr_wdata_i[NumEvents-1:0];
          end
        end

        assign w_src = |(event_i & r_mask);

`ifdef IBEX_HPM_OVF_IRQ_EN
        // Sticky overflow flag; a wrap beats a same-cycle clearing write.
        logic r_of;
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            r_of <= 1'b0;
          end else if (w_wrap[n]) begin
            r_of <= 1'b1;
          end else if (w_we_evt && !csr_wdata_i[CSR_MHPMEVENT_OF_BIT]) begin
            r_of <= 1'b0;
          end
        end
        assign w_of[n] = r_of;
`else
        assign w_of[n] = 1'b0;
`endif

        always_comb begin
          w_rd                       = '0;
          w_rd[NumEvents-1:0]        = r_mask;
          w_rd[CSR_MHPMEVENT_OF_BIT] = w_of[n];
        end
        assign w_evt_rd[n] = w_rd;
      end

      assign w_inc   = w_src && !r_inhibit[n] && !debug_stopcount_i;
      assign w_we_lo = csr_we_i && w_sel_lo && (w_idx == 5'(n));
      assign w_we_hi = csr_we_i && w_sel_hi && (w_idx == 5'(n));

      ibex_hpm_counter #(
        .Width (W)
      ) u_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_inc),
        .we_lo_i (w_we_lo),
        .we_hi_i (w_we_hi),
        .wdata_i (csr_wdata_i),
        .value_o (w_val[n]),
        .wrap_c  (w_wrap[n])
      );
    end else begin : g_none
      assign w_val[n]    = '0;
      assign w_evt_rd[n] = '0;
      assign w_wrap[n]   = 1'b0;
      assign w_of[n]     = 1'b0;
    end
  end

  assign w_unused_wrap = |w_wrap;

  always_comb begin
    csr_rdata_o = '0;
    if (w_sel_inh) begin
      csr_rdata_o = r_inhibit;
    end else if (w_sel_evt) begin
      csr_rdata_o = w_evt_rd[w_idx];
    end else if (w_sel_lo) begin
      csr_rdata_o = w_val[w_idx][31:0];
    end else if (w_sel_hi) begin
      csr_rdata_o = w_val[w_idx][63:32];
    end
  end

`ifdef IBEX_HPM_OVF_IRQ_EN
  logic r_ovf_irq;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf_irq <= 1'b0;
    end else begin
      r_ovf_irq <= |w_of;
    end
  end
  assign ovf_irq_o = r_ovf_irq;
`else
  assign ovf_irq_o = 1'b0;
`endif

endmodule
